dice_roll_gen: RTL and testbench

DICE_ROLL_GEN -- requirements
Module: dice_roll_gen

---
 rtl/dice_pkg.sv | 22 ++
 rtl/dice_lfsr16.sv | 38 +++
 rtl/dice_roll_gen.sv | 113 +++++++++++
 tb/tb_dice_roll_gen.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/dice_pkg.sv
// Shared constants, state encoding and LFSR step function for the six-die roll generator.
package dice_pkg;

   localparam int FACE_COUNT = 6;
   localparam int DIE_W      = 3;
   localparam int LFSR_W     = 16;

   localparam logic [LFSR_W-1:0] LFSR_MASK    = 16'hB400;
   localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

   typedef enum logic [1:0] {
      IDLE,
      ROLL,
      HOLD
   } state_e;

   // Right-shifting Galois step for x^16+x^14+x^13+x^11+1.
   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
      return (s >> 1) ^ (s[0] ? LFSR_MASK : '0);
   endfunction

endpackage

// File: rtl/dice_lfsr16.sv
// 16-bit Galois LFSR with seed load; an all-zero seed is replaced by SEED so the
// register can never enter the lock-up state.
module dice_lfsr16
   import dice_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [LFSR_W-1:0] load_val,
   input  logic              en,
   output logic [LFSR_W-1:0] state
);

   logic [LFSR_W-1:0] lfsr_q;
   logic [LFSR_W-1:0] lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (load) begin
         lfsr_d = (load_val == '0) ? SEED : load_val;
      end else if (en) begin
         lfsr_d = lfsr_step(lfsr_q);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign state = lfsr_q;

endmodule

// File: rtl/dice_roll_gen.sv
// Six-die roll generator: rejection-samples LFSR[2:0] into six die registers and
// presents the completed roll with a valid/ready handshake.
module dice_roll_gen
   import dice_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              seed_load,
   input  logic [LFSR_W-1:0] seed,
   input  logic              roll_req,
   input  logic              ready,
   output logic [DIE_W-1:0]  D1,
   output logic [DIE_W-1:0]  D2,
   output logic [DIE_W-1:0]  D3,
   output logic [DIE_W-1:0]  D4,
   output logic [DIE_W-1:0]  D5,
   output logic [DIE_W-1:0]  D6,
   output logic              valid,
   output logic              busy,
   output logic [7:0]        roll_count
);

   state_e            state_q, state_d;
   logic [2:0]        k_q, k_d;
   logic [7:0]        count_q, count_d;
   logic [DIE_W-1:0]  die_q [FACE_COUNT];

   logic [LFSR_W-1:0] lfsr_state;
   logic [DIE_W-1:0]  cand;
   logic              accept;
   logic              lfsr_load;
   logic              lfsr_en;
   logic              unused_lfsr_hi;

   assign cand           = lfsr_state[DIE_W-1:0];
   assign unused_lfsr_hi = ^lfsr_state[LFSR_W-1:DIE_W];
   assign accept         = (state_q == ROLL) && (cand < DIE_W'(FACE_COUNT));
   assign lfsr_load      = (state_q == IDLE) && seed_load;
   assign lfsr_en        = (state_q == ROLL);

   dice_lfsr16 #(
      .SEED(SEED)
   ) u_lfsr (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (lfsr_load),
      .load_val (seed),
      .en       (lfsr_en),
      .state    (lfsr_state)
   );

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      count_d = count_q;
      unique case (state_q)
         IDLE: begin
            if (roll_req) begin
               state_d = ROLL;
               k_d     = '0;
            end
         end
         ROLL: begin
            if (accept) begin
               if (k_q == 3'(FACE_COUNT - 1)) begin
                  state_d = HOLD;
               end else begin
                  k_d = k_q + 3'd1;
               end
            end
         end
         HOLD: begin
            if (ready) begin
               state_d = IDLE;
               count_d = count_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         k_q     <= '0;
         count_q <= '0;
         for (int i = 0; i < FACE_COUNT; i++) begin
            die_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         count_q <= count_d;
         // Rejected candidates leave every die untouched.
         if (accept) begin
            die_q[k_q] <= cand;
         end
      end
   end

   assign D1         = die_q[0];
   assign D2         = die_q[1];
   assign D3         = die_q[2];
   assign D4         = die_q[3];
   assign D5         = die_q[4];
   assign D6         = die_q[5];
   assign valid      = (state_q == HOLD);
   assign busy       = (state_q == ROLL);
   assign roll_count = count_q;

endmodule

// File: tb/tb_dice_roll_gen.sv
// Self-checking bench for dice_roll_gen: table-driven rolls against an LFSR reference
// model through a scoreboard queue, plus reset, wrap and face-coverage sequences.
module tb_dice_roll_gen;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        seed_load;
   logic [15:0] seed;
   logic        roll_req;
   logic        ready;
   logic [2:0]  D1, D2, D3, D4, D5, D6;
   logic        valid;
   logic        busy;
   logic [7:0]  roll_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dice_roll_gen #(.SEED(16'hACE1)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .seed_load  (seed_load),
      .seed       (seed),
      .roll_req   (roll_req),
      .ready      (ready),
      .D1         (D1),
      .D2         (D2),
      .D3         (D3),
      .D4         (D4),
      .D5         (D5),
      .D6         (D6),
      .valid      (valid),
      .busy       (busy),
      .roll_count (roll_count)
   );

   typedef struct {
      logic [17:0] dice;
      int          lat;
   } exp_t;

   typedef struct {
      logic        ld;
      logic [15:0] sd;
      int          hold_n;
      logic        known;
      logic [17:0] exp_dice;
      logic        same_prev;
   } vec_t;

   exp_t        sb[$];
   vec_t        vecs[6];
   logic [15:0] m_lfsr;
   logic [7:0]  m_count;
   int          hist[8];

   function automatic logic [17:0] dice_now();
      return {D6, D5, D4, D3, D2, D1};
   endfunction

   function automatic logic [15:0] m_step(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference roll: rejection sampling on the low three bits, one step per ROLL cycle.
   task automatic model_roll(output exp_t e);
      int k = 0;
      int r = 0;
      e.dice = '0;
      while (k < 6) begin
         if (m_lfsr[2:0] < 3'd6) begin
            e.dice[3*k +: 3] = m_lfsr[2:0];
            k++;
         end
         m_lfsr = m_step(m_lfsr);
         r++;
      end
      e.lat = r + 1;
   endtask

   task automatic check_cleared(input string tag);
      chk({tag, "_valid"}, 32'(valid), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_dice"}, 32'(dice_now()), 32'd0);
      chk({tag, "_count"}, 32'(roll_count), 32'(m_count));
   endtask

   task automatic apply_reset(input int cycles);
      @(negedge clk);
      rst_n = 1'b0;
      repeat (cycles) @(negedge clk);
      rst_n   = 1'b1;
      m_lfsr  = 16'hACE1;
      m_count = 8'd0;
   endtask

   task automatic do_roll(input logic ld, input logic [15:0] sd, input int hold_n,
                          output logic [17:0] got);
      exp_t        e;
      exp_t        ex;
      int          n;
      logic [17:0] held;
      logic        stable;
      @(negedge clk);
      seed_load = ld;
      seed      = sd;
      roll_req  = 1'b1;
      if (ld) m_lfsr = (sd == 16'h0) ? 16'hACE1 : sd;
      model_roll(e);
      sb.push_back(e);
      @(negedge clk);
      seed_load = 1'b0;
      roll_req  = 1'b0;
      chk("busy_in_roll", 32'(busy), 32'd1);
      n = 1;
      while (!valid && n < 400) begin
         @(negedge clk);
         n++;
      end
      ex  = sb.pop_front();
      got = dice_now();
      if (!valid) begin
         checks++;
         errors++;
         $display("FAIL valid_timeout actual=0 required=1 after %0d cycles", n);
      end
      chk("latency", 32'(n), 32'(ex.lat));
      chk("dice", 32'(got), 32'(ex.dice));
      chk("busy_in_hold", 32'(busy), 32'd0);
      for (int i = 0; i < 6; i++) hist[got[3*i +: 3]]++;
      held   = got;
      stable = 1'b1;
      for (int i = 0; i < hold_n; i++) begin
         // Seed load and roll request while holding must both be ignored.
         if (i == 2) begin
            roll_req  = 1'b1;
            seed_load = 1'b1;
            seed      = 16'h5555;
         end else begin
            roll_req  = 1'b0;
            seed_load = 1'b0;
         end
         @(negedge clk);
         if (!valid || dice_now() !== held) stable = 1'b0;
      end
      roll_req  = 1'b0;
      seed_load = 1'b0;
      if (hold_n > 0) chk("hold_stable", 32'(stable), 32'd1);
      ready = 1'b1;
      @(negedge clk);
      ready   = 1'b0;
      m_count = m_count + 8'd1;
      chk("post_hs_valid", 32'(valid), 32'd0);
      chk("post_hs_count", 32'(roll_count), 32'(m_count));
      chk("post_hs_dice_kept", 32'(dice_now()), 32'(held));
      $display("roll ld=%0d seed=%h dice=%h lat=%0d count=%0d", ld, sd, got, n, roll_count);
   endtask

   initial begin
      logic [17:0] got;
      logic [17:0] prev;
      int          n;

      //                ld    seed      hold known exp(D6..D1)                              same_prev
      vecs[0] = '{1'b0, 16'h0000, 0,  1'b1, {3'd1,3'd3,3'd4,3'd0,3'd0,3'd1}, 1'b0};
      vecs[1] = '{1'b1, 16'h0000, 3,  1'b1, {3'd1,3'd3,3'd4,3'd0,3'd0,3'd1}, 1'b0};
      vecs[2] = '{1'b1, 16'h1234, 0,  1'b0, 18'h0,                           1'b0};
      vecs[3] = '{1'b1, 16'h1234, 2,  1'b0, 18'h0,                           1'b1};
      vecs[4] = '{1'b0, 16'h0000, 20, 1'b0, 18'h0,                           1'b0};
      vecs[5] = '{1'b1, 16'hBEEF, 1,  1'b0, 18'h0,                           1'b0};

      rst_n     = 1'b0;
      seed_load = 1'b0;
      seed      = 16'h0;
      roll_req  = 1'b0;
      ready     = 1'b0;
      m_lfsr    = 16'hACE1;
      m_count   = 8'd0;
      prev      = '0;
      for (int i = 0; i < 8; i++) hist[i] = 0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check_cleared("reset");

      // Reset asserted on the third ROLL cycle discards the partial roll.
      @(negedge clk);
      roll_req = 1'b1;
      @(negedge clk);
      roll_req = 1'b0;
      n = 1;
      while (n < 3) begin
         @(negedge clk);
         n++;
      end
      chk("midroll_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n  = 1'b1;
      m_lfsr = 16'hACE1;
      check_cleared("midroll_reset");

      for (int v = 0; v < 6; v++) begin
         do_roll(vecs[v].ld, vecs[v].sd, vecs[v].hold_n, got);
         if (vecs[v].known) chk("known_vector", 32'(got), 32'(vecs[v].exp_dice));
         if (vecs[v].same_prev) chk("same_seed_repeat", 32'(got), 32'(prev));
         prev = got;
      end

      apply_reset(2);
      check_cleared("reset2");
      for (int i = 0; i < 8; i++) hist[i] = 0;
      for (int r = 0; r < 256; r++) begin
         do_roll(1'b0, 16'h0, 0, got);
      end
      chk("count_wrap", 32'(roll_count), 32'd0);
      for (int f = 0; f < 6; f++) chk($sformatf("face%0d_seen", f), 32'(hist[f] > 0), 32'd1);
      chk("face6_absent", 32'(hist[6]), 32'd0);
      chk("face7_absent", 32'(hist[7]), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
